mul_seq_ctrl: RTL and testbench

//  Sequencing controller that computes an unsigned OPW x OPW product by time-multiplexing one
//  4x4 unsigned array-multiplier core over nibble pairs, accumulating shifted partial products.

---
 rtl/mul_seq_ctrl_pkg.sv | 17 +
 rtl/mul_seq_ctrl_if.sv | 25 ++
 rtl/mul4x4_core.sv | 32 +++
 rtl/mul_seq_ctrl.sv | 115 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial multiplier controller.
package mul_seq_ctrl_pkg;

  localparam int unsigned NIB = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StHold = 2'd2
  } state_e;

  // Counter width for K nibble positions, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Operand/result handshake bundle between producer, controller and consumer.
interface mul_seq_ctrl_if #(
  parameter int unsigned OPW = 8
) ();

  logic               in_valid;
  logic               in_ready;
  logic [OPW-1:0]     a;
  logic [OPW-1:0]     b;
  logic               out_valid;
  logic               out_ready;
  logic [2*OPW-1:0]   p;
  logic               busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );

endinterface

// File: rtl/mul4x4_core.sv
// Combinational unsigned 4x4 array multiplier: AND partial products, three 4-bit ripple rows.
module mul4x4_core (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [3:0] pp  [4];
  logic [4:0] row [4];

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      pp[r] = a & {4{b[r]}};
    end
    row[0] = {1'b0, pp[0]};
    // Each row adds the next partial product to the upper bits of the previous row.
    for (int r = 1; r < 4; r++) begin
      logic       c;
      logic [3:0] x;
      c = 1'b0;
      x = row[r-1][4:1];
      row[r] = '0;
      for (int k = 0; k < 4; k++) begin
        row[r][k] = x[k] ^ pp[r][k] ^ c;
        c = (x[k] & pp[r][k]) | (x[k] & c) | (pp[r][k] & c);
      end
      row[r][4] = c;
    end
    p = {row[3], row[2][0], row[1][0], row[0][0]};
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential OPW x OPW multiplier reusing one 4x4 core over all nibble pairs.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 8
) (
  input  logic           clk,
  input  logic           rst,
  mul_seq_ctrl_if.slave  bus
);

  localparam int unsigned K  = OPW / NIB;
  localparam int unsigned IW = idx_width(K);
  localparam int unsigned PW = 2 * OPW;
  localparam logic [IW-1:0] Last = IW'(K - 1);

  state_e          state_q, state_d;
  logic [OPW-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d, p_q, p_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d;
  logic            out_valid_q, out_valid_d;

  logic [NIB-1:0]   core_a, core_b;
  logic [2*NIB-1:0] pp;
  logic [PW-1:0]    step;
  int unsigned      a_base, b_base, shamt;

  always_comb begin
    a_base = NIB * 32'(i_q);
    b_base = NIB * 32'(j_q);
    shamt  = a_base + b_base;
    core_a = a_q[a_base +: NIB];
    core_b = b_q[b_base +: NIB];
    step   = PW'(pp) << shamt;
  end

  mul4x4_core u_core (
    .a (core_a),
    .b (core_b),
    .p (pp)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        acc_d = acc_q + step;
        if (j_q == Last) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
        if (i_q == Last && j_q == Last) begin
          i_d         = '0;
          p_d         = acc_d;
          out_valid_d = 1'b1;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.busy      = (state_q != StIdle);
  assign bus.p         = p_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed and random checks of mul_seq_ctrl at OPW=8 and OPW=12.
module tb_mul_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl_if #(.OPW(8))  bus8 ();
  mul_seq_ctrl_if #(.OPW(12)) bus12 ();

  mul_seq_ctrl #(.OPW(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  mul_seq_ctrl #(.OPW(12)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair; lat = edges from accept to out_valid, -1 on timeout.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat,
                      output logic [15:0] p, output logic rdy_seen);
    bus8.in_valid = 1'b1;
    bus8.a        = a;
    bus8.b        = b;
    tick();
    bus8.in_valid = 1'b0;
    lat      = 0;
    rdy_seen = 1'b0;
    while (!bus8.out_valid && lat < 40) begin
      if (bus8.in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    if (bus8.in_ready) rdy_seen = 1'b1;
    if (!bus8.out_valid) lat = -1;
    p = bus8.p;
  endtask

  task automatic run12(input logic [11:0] a, input logic [11:0] b, output int lat,
                       output logic [23:0] p);
    bus12.in_valid = 1'b1;
    bus12.a        = a;
    bus12.b        = b;
    tick();
    bus12.in_valid = 1'b0;
    lat = 0;
    while (!bus12.out_valid && lat < 60) begin
      tick();
      lat++;
    end
    if (!bus12.out_valid) lat = -1;
    p = bus12.p;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus8.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_ready cyc %0d got %b want 0", c, bus8.in_ready);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.p !== 16'h0 || bus8.busy !== 1'b0 ||
        bus8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got ov=%b p=%h busy=%b rdy=%b want ov=0 p=0000 busy=0 rdy=1",
               bus8.out_valid, bus8.p, bus8.busy, bus8.in_ready);
    end
  endtask

  task automatic test_max();
    int lat;
    logic [15:0] p;
    logic rdy;
    bus8.out_ready = 1'b1;
    run8(8'hFF, 8'hFF, lat, p, rdy);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL max_latency got %0d want 4", lat);
    end
    checks++;
    if (p !== 16'hFE01) begin
      errors++;
      $display("FAIL max_product got %h want fe01", p);
    end
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL max_in_ready_busy got %b want 0", rdy);
    end
    tick();
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL max_handoff got ov=%b rdy=%b want ov=0 rdy=1", bus8.out_valid, bus8.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va [3] = '{8'h00, 8'h0F, 8'h12};
    logic [7:0]  vb [3] = '{8'hA5, 8'h10, 8'h34};
    logic [15:0] vp [3] = '{16'h0000, 16'h00F0, 16'h03A8};
    int lat;
    logic [15:0] p;
    logic rdy;
    bus8.out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      run8(va[n], vb[n], lat, p, rdy);
      checks++;
      if (p !== vp[n] || lat !== 4) begin
        errors++;
        $display("FAIL b2b_op%0d got p=%h lat=%0d want p=%h lat=4", n, p, lat, vp[n]);
      end
      checks++;
      if (bus8.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hold_ready%0d got %b want 0", n, bus8.in_ready);
      end
      tick();
      checks++;
      if (bus8.in_ready !== 1'b1 || bus8.busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle_gap%0d got rdy=%b busy=%b want rdy=1 busy=0", n, bus8.in_ready,
                 bus8.busy);
      end
    end
  endtask

  task automatic test_stall();
    int lat;
    logic [15:0] p;
    logic rdy;
    bus8.out_ready = 1'b0;
    run8(8'h9C, 8'h7B, lat, p, rdy);
    checks++;
    if (p !== 16'h4AF4 || lat !== 4) begin
      errors++;
      $display("FAIL stall_op got p=%h lat=%0d want p=4af4 lat=4", p, lat);
    end
    for (int c = 0; c < 10; c++) begin
      bus8.in_valid = c[0];
      bus8.a        = 8'h11;
      bus8.b        = 8'h22;
      tick();
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.p !== 16'h4AF4 || bus8.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got ov=%b p=%h rdy=%b want ov=1 p=4af4 rdy=0", c,
                 bus8.out_valid, bus8.p, bus8.in_ready);
      end
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    tick();
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.p !== 16'h4AF4) begin
      errors++;
      $display("FAIL stall_release got ov=%b rdy=%b p=%h want ov=0 rdy=1 p=4af4",
               bus8.out_valid, bus8.in_ready, bus8.p);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    logic [15:0] p;
    logic rdy;
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.a         = 8'hAB;
    bus8.b         = 8'hCD;
    tick();
    bus8.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus8.busy !== 1'b0 || bus8.p !== 16'h0 || bus8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got busy=%b p=%h ov=%b want busy=0 p=0000 ov=0", bus8.busy,
               bus8.p, bus8.out_valid);
    end
    rst = 1'b0;
    #1;
    run8(8'h12, 8'h34, lat, p, rdy);
    checks++;
    if (p !== 16'h03A8 || lat !== 4) begin
      errors++;
      $display("FAIL abort_rerun got p=%h lat=%0d want p=03a8 lat=4", p, lat);
    end
    tick();
  endtask

  task automatic test_wide_and_random();
    int lat;
    logic [15:0] p8;
    logic [23:0] p12;
    logic [7:0]  a8, b8;
    logic [11:0] a12, b12;
    logic rdy;
    bus12.out_ready = 1'b1;
    bus8.out_ready  = 1'b1;
    run12(12'hFFF, 12'hFFF, lat, p12);
    checks++;
    if (p12 !== 24'hFFE001 || lat !== 9) begin
      errors++;
      $display("FAIL wide_max got p=%h lat=%0d want p=ffe001 lat=9", p12, lat);
    end
    tick();
    for (int n = 0; n < 1000; n++) begin
      a12 = 12'($urandom);
      b12 = 12'($urandom);
      run12(a12, b12, lat, p12);
      checks++;
      if (p12 !== 24'(a12) * 24'(b12) || lat !== 9) begin
        errors++;
        $display("FAIL rand12 %h*%h got p=%h lat=%0d want p=%h lat=9", a12, b12, p12, lat,
                 24'(a12) * 24'(b12));
      end
      tick();
    end
    for (int n = 0; n < 1000; n++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      run8(a8, b8, lat, p8, rdy);
      checks++;
      if (p8 !== 16'(a8) * 16'(b8) || lat !== 4) begin
        errors++;
        $display("FAIL rand8 %h*%h got p=%h lat=%0d want p=%h lat=4", a8, b8, p8, lat,
                 16'(a8) * 16'(b8));
      end
      tick();
    end
  endtask

  initial begin
    bus8.in_valid   = 1'b0;
    bus8.a          = '0;
    bus8.b          = '0;
    bus8.out_ready  = 1'b0;
    bus12.in_valid  = 1'b0;
    bus12.a         = '0;
    bus12.b         = '0;
    bus12.out_ready = 1'b0;
    test_reset();
    test_max();
    test_back_to_back();
    test_stall();
    test_reset_abort();
    test_wide_and_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
